// File: rtl/kf_fxp_pkg.sv
// Shared fixed-point definitions for the Kalman filter datapath: default word
// geometry, the Q-format one constant, the word type and a tag-width helper.
package kf_fxp_pkg;

  localparam int FXP_N = 32;
  localparam int FXP_Q = 18;

  localparam logic [FXP_N-1:0] FXP_ONE = 32'(1) << FXP_Q;

  typedef logic signed [FXP_N-1:0] fxp_t;

  // Tag width for n requesters; never narrower than one bit.
  function automatic int max_id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fxp_mul_core.sv
// Combinational signed Q-format multiply: sign-magnitude product truncated
// toward zero, with an overflow flag for any magnitude bits above the result.
module fxp_mul_core #(
  parameter int N = 32,
  parameter int Q = 18
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] result_o,
  output logic         ovr_o
);

  logic [N-1:0]   mag_a, mag_b, mres;
  logic [2*N-1:0] prod;
  logic           neg;
  logic [Q-1:0]   unused_frac;

  // The most negative word negates to itself, which is its correct unsigned magnitude.
  assign mag_a = a_i[N-1] ? (~a_i + 1'b1) : a_i;
  assign mag_b = b_i[N-1] ? (~b_i + 1'b1) : b_i;
  assign neg   = a_i[N-1] ^ b_i[N-1];

  assign prod        = {{N{1'b0}}, mag_a} * {{N{1'b0}}, mag_b};
  assign mres        = prod[N-1+Q:Q];
  assign unused_frac = prod[Q-1:0];

  // A negative product that truncates to zero stays zero rather than -LSB.
  assign result_o = (neg && (mres != '0)) ? (~mres + 1'b1) : mres;
  assign ovr_o    = |prod[2*N-1:N-1+Q];

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin front end sharing one fixed-point multiplier among NUM_REQ
// requesters; two-stage pipeline. Optional sticky overflow: MULT_ARB_OVR_STICKY_EN.
module mult_arbiter
  import kf_fxp_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int N       = FXP_N,
  parameter int Q       = FXP_Q,
  parameter int ID_W    = max_id_w(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*N-1:0] req_a,
  input  logic [NUM_REQ*N-1:0] req_b,
  output logic                 rsp_valid,
  output logic [ID_W-1:0]      rsp_id,
  output logic [N-1:0]         rsp_result,
  output logic                 rsp_ovr,
  output logic [NUM_REQ-1:0]   ovr_sticky,
  input  logic [NUM_REQ-1:0]   ovr_clr,
  output logic                 busy
);

  localparam int STAGES = 2;

  logic [ID_W-1:0]    ptr_q;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_id;
  logic               xfer;

  logic [STAGES:1]    vld_pipe_q;
  logic [N-1:0]       a1_q, b1_q, a1_d, b1_d;
  logic [ID_W-1:0]    id1_q, id2_q;
  logic [N-1:0]       res2_q, mul_res;
  logic               ovr2_q, mul_ovr;

  // Search upward from ptr+1 with wrap; first valid requester wins.
  always_comb begin
    int idx;
    idx    = 0;
    gnt    = '0;
    gnt_id = '0;
    xfer   = 1'b0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = (int'(ptr_q) + off) % NUM_REQ;
      if (!xfer && req_valid[idx]) begin
        xfer        = 1'b1;
        gnt[idx]    = 1'b1;
        gnt_id      = ID_W'(idx);
      end
    end
    if (!en || !rst_n) begin
      gnt  = '0;
      xfer = 1'b0;
    end
  end

  assign req_ready = gnt;
  assign a1_d      = req_a[int'(gnt_id)*N +: N];
  assign b1_d      = req_b[int'(gnt_id)*N +: N];

  fxp_mul_core #(.N(N), .Q(Q)) u_mul (
    .a_i      (a1_q),
    .b_i      (b1_q),
    .result_o (mul_res),
    .ovr_o    (mul_ovr)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q      <= ID_W'(NUM_REQ-1);
      vld_pipe_q <= '0;
      a1_q       <= '0;
      b1_q       <= '0;
      id1_q      <= '0;
      id2_q      <= '0;
      res2_q     <= '0;
      ovr2_q     <= 1'b0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[STAGES-1:1], xfer};
      if (xfer) begin
        ptr_q <= gnt_id;
        a1_q  <= a1_d;
        b1_q  <= b1_d;
        id1_q <= gnt_id;
      end
      // Stage 2 holds its last result between strobes.
      if (vld_pipe_q[1]) begin
        res2_q <= mul_res;
        ovr2_q <= mul_ovr;
        id2_q  <= id1_q;
      end
    end
  end

  assign rsp_valid  = vld_pipe_q[STAGES];
  assign rsp_id     = id2_q;
  assign rsp_result = res2_q;
  assign rsp_ovr    = ovr2_q;
  assign busy       = |vld_pipe_q;

`ifdef MULT_ARB_OVR_STICKY_EN
  logic [NUM_REQ-1:0] sticky_q;

  // A new overflow takes precedence over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sticky_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (vld_pipe_q[STAGES] && ovr2_q && (id2_q == ID_W'(i)))
          sticky_q[i] <= 1'b1;
        else if (ovr_clr[i])
          sticky_q[i] <= 1'b0;
      end
    end
  end

  assign ovr_sticky = sticky_q;
`else
  logic unused_clr;
  assign unused_clr = ^ovr_clr;
  assign ovr_sticky = '0;
`endif

endmodule

// File: tb/tb_mult_arbiter.sv
// Scoreboard bench for mult_arbiter: handshakes push hand-computed results,
// a negedge monitor pops and compares them against each response strobe.
module tb_mult_arbiter;

  localparam int NR = 4;
  localparam int W  = 32;

`ifdef MULT_ARB_OVR_STICKY_EN
  localparam logic STICKY_ON = 1'b1;
`else
  localparam logic STICKY_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n, en;
  logic [NR-1:0]    req_valid, req_ready, ovr_sticky, ovr_clr;
  logic [NR*W-1:0]  req_a, req_b;
  logic             rsp_valid, rsp_ovr, busy;
  logic [1:0]       rsp_id;
  logic [W-1:0]     rsp_result;

  mult_arbiter #(.NUM_REQ(NR), .N(W), .Q(18)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_ovr(rsp_ovr),
    .ovr_sticky(ovr_sticky), .ovr_clr(ovr_clr), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          id;
    logic [31:0] res;
    logic        ovr;
    int          due;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] exp_r[NR];
  logic        exp_o[NR];
  int          n_chk  = 0;
  int          n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, req, cyc);
  endtask

  // Issue side of the scoreboard: every accepted handshake owes a response at +2.
  always @(negedge clk) begin
    for (int i = 0; i < NR; i++)
      if (rst_n && req_valid[i] && req_ready[i])
        sbq.push_back('{id: i, res: exp_r[i], ovr: exp_o[i], due: cyc + 2});
  end

  always @(negedge clk) begin
    if (rsp_valid) begin
      if (sbq.size() == 0) begin
        n_chk++;
        $display("FAIL rsp_unexpected: got id %0d result 0x%0h expected no response (cycle %0d)",
                 rsp_id, rsp_result, cyc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("rsp_id", 64'(rsp_id), 64'(e.id));
        chk("rsp_result", 64'(rsp_result), 64'(e.res));
        chk("rsp_ovr", 64'(rsp_ovr), 64'(e.ovr));
        chk("rsp_latency", 64'(cyc), 64'(e.due));
      end
    end
  end

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input logic eo);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    exp_r[i]        = er;
    exp_o[i]        = eo;
    req_valid[i]    = 1'b1;
  endtask

  // Returns in the cycle after the transfer, with the requester's valid dropped.
  task automatic wait_grant(input int i, output int g);
    bit got;
    got = 1'b0;
    g   = -1;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (req_ready[i]) begin
        got = 1'b1;
        g   = cyc;
        chk("gnt_onehot", 64'(req_ready), 64'(1) << i);
      end
    end
    if (!got) begin
      n_chk++;
      $display("FAIL gnt_timeout: requester %0d got no grant, expected one within 20 cycles", i);
    end
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
  endtask

  initial begin
    int g;
    rst_n = 1'b0; en = 1'b1; req_valid = '1; ovr_clr = '0;
    req_a = '0; req_b = '0;
    for (int i = 0; i < NR; i++) begin exp_r[i] = '0; exp_o[i] = 1'b0; end

    // Reset with all requesters valid.
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_sticky", 64'(ovr_sticky), 64'd0);
    chk("rst_rsp_result", 64'(rsp_result), 64'd0);
    @(posedge clk); #1;
    req_valid = '0; rst_n = 1'b1;

    // Single op and sign handling.
    set_req(2, 32'h0008_0000, 32'h000C_0000, 32'h0018_0000, 1'b0);
    wait_grant(2, g);
    chk("busy_inflight", 64'(busy), 64'd1);
    set_req(1, 32'hFFFA_0000, 32'h0008_0000, 32'hFFF4_0000, 1'b0);
    wait_grant(1, g);
    set_req(3, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0);
    wait_grant(3, g);
    set_req(3, 32'hFFF8_0000, 32'hFFF4_0000, 32'h0018_0000, 1'b0);
    wait_grant(3, g);
    repeat (4) @(negedge clk);
    chk("idle_busy", 64'(busy), 64'd0);

    // Fairness: pointer sits at 3, so 0 leads.
    @(posedge clk); #1;
    for (int i = 0; i < NR; i++)
      set_req(i, 32'(i + 1) << 18, 32'h0004_0000, 32'(i + 1) << 18, 1'b0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("rr_grant", 64'(req_ready), 64'(1) << (k % NR));
    end
    @(posedge clk); #1;
    req_valid = '0;
    repeat (4) @(negedge clk);

    // Single requester granted every cycle.
    @(posedge clk); #1;
    set_req(1, 32'h0004_0000, 32'h0004_0000, 32'h0004_0000, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("single_grant", 64'(req_ready), 64'b0010);
    end
    @(posedge clk); #1;
    req_valid = '0;
    repeat (4) @(negedge clk);

    // Overflow and sticky flag.
    @(posedge clk); #1;
    set_req(0, 32'h4000_0000, 32'h4000_0000, 32'h0000_0000, 1'b1);
    wait_grant(0, g);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("sticky_set", 64'(ovr_sticky), 64'(STICKY_ON));
    repeat (2) @(negedge clk);
    chk("sticky_hold", 64'(ovr_sticky), 64'(STICKY_ON));
    @(posedge clk); #1;
    ovr_clr[0] = 1'b1;
    @(posedge clk); #1;
    ovr_clr[0] = 1'b0;
    @(negedge clk);
    chk("sticky_clr", 64'(ovr_sticky), 64'd0);
    @(posedge clk); #1;
    set_req(0, 32'h4000_0000, 32'h4000_0000, 32'h0000_0000, 1'b1);
    wait_grant(0, g);
    @(posedge clk); #1;
    ovr_clr[0] = 1'b1;
    @(posedge clk); #1;
    ovr_clr[0] = 1'b0;
    @(negedge clk);
    chk("sticky_set_wins", 64'(ovr_sticky), 64'(STICKY_ON));
    repeat (3) @(negedge clk);

    // Reset one cycle after a grant discards the operation.
    @(posedge clk); #1;
    set_req(1, 32'h0008_0000, 32'h0008_0000, 32'h0010_0000, 1'b0);
    wait_grant(1, g);
    rst_n = 1'b0;
    sbq.delete();
    req_valid = '1;
    @(negedge clk);
    chk("rst_mid_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    chk("rst_mid_no_rsp", 64'(rsp_valid), 64'd0);
    @(posedge clk); #1;
    req_valid = '0; rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_sticky", 64'(ovr_sticky), 64'd0);

    // Dropping en after a grant: response still arrives, no new grants.
    @(posedge clk); #1;
    set_req(3, 32'h000C_0000, 32'h000C_0000, 32'h0024_0000, 1'b0);
    wait_grant(3, g);
    en = 1'b0;
    set_req(2, 32'h0004_0000, 32'hFFFC_0000, 32'hFFFC_0000, 1'b0);
    @(negedge clk);
    chk("en_off_ready1", 64'(req_ready), 64'd0);
    chk("en_off_busy1", 64'(busy), 64'd1);
    @(negedge clk);
    chk("en_off_ready2", 64'(req_ready), 64'd0);
    chk("en_off_busy2", 64'(busy), 64'd1);
    @(negedge clk);
    chk("en_off_busy3", 64'(busy), 64'd0);
    chk("en_off_ready3", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    en = 1'b1;
    wait_grant(2, g);
    repeat (5) @(negedge clk);

    chk("sb_drained", 64'(sbq.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mult_arbiter.md
# mult_arbiter

Round-robin scheduler that shares one signed Q-format fixed-point multiplier among `NUM_REQ` requesters in the Kalman filter datapath. The block accepts operand pairs over valid/ready handshakes, issues them to the multiplier, and returns each tagged result to its owner. It is fully pipelined, with one issue per cycle and a fixed response latency. It sits between the state-update/covariance engines and the multiplier core.

## Interface
- `NUM_REQ`, 4: number of requesters; range 2..8.
- `N`, 32: total word width.
- `Q`, 18: fraction bits.
- `ID_W`, `$clog2(NUM_REQ)`: requester tag width.
- `clk`, in, 1: single clock; all logic on the rising edge.
- `rst_n`, in, 1: reset is synchronous and active-low.
- `en`, in, 1: grant enable; when low, no new grants and the pipeline still drains.
- `req_valid`, in, `NUM_REQ`: per-requester operand valid.
- `req_ready`, out, `NUM_REQ`: one-hot grant; combinational from `req_valid`, `en` and the priority pointer.
- `req_a`, in, `NUM_REQ*N`: packed operand A; requester i occupies `[i*N +: N]`.
- `req_b`, in, `NUM_REQ*N`: packed operand B, same packing as `req_a`.
- `rsp_valid`, out, 1: result strobe, one cycle wide; there is no backpressure.
- `rsp_id`, out, `ID_W`: index of the requester that owns the result.
- `rsp_result`, out, N: Q-format product.
- `rsp_ovr`, out, 1: overflow flag for this result.
- `ovr_sticky`, out, `NUM_REQ`: per-requester latched overflow.
- `ovr_clr`, in, `NUM_REQ`: per-requester clear for `ovr_sticky`.
- `busy`, out, 1: high while any operation is in flight.

## Operation
- **Arbitration**
  - Round-robin, searching upward from `ptr+1` and wrapping modulo `NUM_REQ`.
  - The first requester found with `req_valid` high gets `req_ready`.
  - On a transfer (valid & ready), `ptr` is set to the granted index.
  - `ptr` resets to `NUM_REQ-1`, so requester 0 has top priority after reset.
  - A requester holds `req_a`, `req_b` and `req_valid` stable until granted.
  - When `en` is low, `req_ready` is all zero and `ptr` holds.
- **Pipeline**
  - Stage 1 registers the operands, the tag and a valid bit on the transfer.
  - The combinational multiplier acts on stage 1.
  - Stage 2 registers result, overflow, tag and valid; these drive the `rsp_*` outputs.
- **Arithmetic**
  - Negative operands are negated to magnitudes, and the magnitudes are multiplied to 2N bits.
  - Magnitude result = `prod[N-1+Q:Q]`, i.e. truncation toward zero.
  - If the product sign is negative and the magnitude result is nonzero, output the two's-complement negation; otherwise output the magnitude result. Small negative products therefore give exactly 0.
  - `ovr` = 1 when `prod[2N-1:N-1+Q]` is nonzero; the result field is still the truncated bits.
- `busy` = stage-1 valid OR stage-2 valid.

## Timing
- **Reset:** all pipeline valids = 0; `rsp_valid` = 0; `rsp_id`, `rsp_result`, `rsp_ovr` = 0; `ovr_sticky` = 0; `ptr` = `NUM_REQ-1`; `busy` = 0.
- **Reset mid-operation:** in-flight operations are discarded with no `rsp_valid`. `req_ready` is forced to 0 while `rst_n` is low.
- **Latency:** a transfer in cycle T gives `rsp_valid` in cycle T+2. Throughput is one operation per cycle. Response order equals grant order.
- **Back-to-back:** with all requesters valid, grants go 0,1,2,3,0,…, one per cycle with no bubbles.
- **Single requester:** if only one requester is valid, it is granted every cycle.
- **`en` deasserted mid-stream:** operations already granted complete on schedule; `busy` falls 2 cycles after the last grant.
- **Simultaneous `ovr_clr` and a new overflow on the same requester:** set wins.

## Configuration
- **`MULT_ARB_OVR_STICKY_EN` defined:** `ovr_sticky[i]` sets on a response with `rsp_ovr`=1 and `rsp_id`=i, and clears on `ovr_clr[i]`.
- **Not defined:** `ovr_sticky` is tied to 0, `ovr_clr` is ignored, and the latch logic is not compiled. `rsp_ovr` is unaffected.

## Structure
- **Shared package `kf_fxp_pkg`:**
  - Default `N` and `Q`.
  - Q-format constant `FXP_ONE` = `1<<Q`.
  - `fxp_t` typedef (signed `[N-1:0]`).
  - Function `max_id_w(n)`.
- **One sub-module, `fxp_mul_core`:** purely combinational; (a, b) → (result, ovr) per the arithmetic rules. The arbiter contains the grant logic, pointer, pipeline registers and sticky flags.

## Test plan
- **Reset:** hold `rst_n`=0 with `req_valid`=4'b1111 → `req_ready`=0, `rsp_valid`=0, `busy`=0, `ovr_sticky`=0.
- **Single op:** requester 2 sends a=0x00080000 (2.0), b=0x000C0000 (3.0) in cycle T → at T+2, `rsp_valid`=1, `rsp_id`=2, `rsp_result`=0x00180000, `rsp_ovr`=0.
- **Sign handling:**
  - a=0xFFFA0000 (−1.5), b=0x00080000 → `rsp_result`=0xFFF40000 (−3.0).
  - a=0xFFFFFFFF, b=0x00000001 → `rsp_result`=0 (no −LSB).
- **Fairness:** all four requesters valid continuously for 8 cycles → grant sequence 0,1,2,3,0,1,2,3. `rsp_id` follows the same sequence two cycles later.
- **Overflow:** a=b=0x40000000 (4096.0) → `rsp_ovr`=1. With `MULT_ARB_OVR_STICKY_EN`, `ovr_sticky[id]` stays 1 until `ovr_clr[id]` is pulsed; a new overflow arriving in the same cycle as `ovr_clr` keeps it at 1.
- **Mid-op reset / `en`:**
  - Grant in cycle T, then `rst_n`=0 in T+1 → no `rsp_valid` at T+2.
  - Drop `en` after a grant → that response still appears, and no further grants occur.
